// File: rtl/rfi_ctrl_pkg.sv
// Shared types and constants for the rfi_detection sequencer.
// State encoding is software visible through the state output.
package rfi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2,
    ST_DRAIN     = 2'd3
  } state_t;

  localparam int unsigned ACC_LEN_DEFAULT = 1024;

  // Timer widths: the cnt_rst pulse is short, the dump watchdog may be long.
  localparam int RST_W = 8;
  localparam int TO_W  = 32;

  // A zero-length integration is meaningless; stage it as a single spectrum.
  function automatic logic [31:0] stage_len(input logic [31:0] req);
    return (req == 32'd0) ? 32'd1 : req;
  endfunction

endpackage

// File: rtl/rfi_acc_ctrl_if.sv
// Bus between the sequencer and its surroundings: upstream stream,
// software control/status and the rfi_detection handshake.
interface rfi_acc_ctrl_if;
  import rfi_ctrl_pkg::*;

  logic        sync_in;
  logic        din_valid;
  logic        arm;
  logic [31:0] acc_len_reg;
  logic        warn_clr;
  logic        det_valid;
  logic        det_warning;

  logic [31:0] acc_len;
  logic        cnt_rst;
  logic        sync_out;
  logic        busy;
  state_t      state;
  logic [31:0] dump_cnt;
  logic        warn_sticky;
  logic        sync_err;
  logic        cfg_err;
  logic        dump_timeout;

  modport slave (
    input  sync_in, din_valid, arm, acc_len_reg, warn_clr, det_valid, det_warning,
    output acc_len, cnt_rst, sync_out, busy, state, dump_cnt,
           warn_sticky, sync_err, cfg_err, dump_timeout
  );

  modport master (
    output sync_in, din_valid, arm, acc_len_reg, warn_clr, det_valid, det_warning,
    input  acc_len, cnt_rst, sync_out, busy, state, dump_cnt,
           warn_sticky, sync_err, cfg_err, dump_timeout
  );

endinterface

// File: rtl/rfi_sticky_flag.sv
// Sticky status bit: set has priority over clear so an event that
// coincides with a software clear is never lost.
module rfi_sticky_flag (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic flag
);

  logic flag_d;
  logic flag_q;

  always_comb begin
    flag_d = set | (flag_q & ~clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag_q <= 1'b0;
    else     flag_q <= flag_d;
  end

  assign flag = flag_q;

endmodule

// File: rtl/rfi_acc_ctrl.sv
// Sequencer for rfi_detection: arms on request, aligns to the PFB sync,
// stages acc_len on integration boundaries and supervises dump latency.
module rfi_acc_ctrl #(
  parameter int          CHANNEL_ADDR    = 9,
  parameter int unsigned ACC_LEN_DEFAULT = rfi_ctrl_pkg::ACC_LEN_DEFAULT,
  parameter int          RST_CYCLES      = 2,
  parameter int          TIMEOUT         = 4096
) (
  input logic           clk,
  input logic           rst,
  rfi_acc_ctrl_if.slave bus
);
  import rfi_ctrl_pkg::*;

  state_t                  state_q, state_d;
  logic                    arm_q;
  logic [CHANNEL_ADDR-1:0] ch_cnt_q, ch_cnt_d;
  logic [31:0]             spec_cnt_q, spec_cnt_d;
  logic [31:0]             acc_len_q, acc_len_d;
  logic [31:0]             dump_cnt_q, dump_cnt_d;
  logic [RST_W-1:0]        rst_timer_q, rst_timer_d;
  logic [TO_W-1:0]         to_timer_q, to_timer_d;
  logic                    sync_out_q, sync_out_d;
  logic                    cnt_rst_q, cnt_rst_d;

  logic        arm_rise;
  logic        boundary;
  logic        counting;
  logic        int_end;
  logic        bad_sync;
  logic        latch_len;
  logic [31:0] shadow;
  logic        set_warn, set_sync, set_cfg, set_to;

  always_comb begin
    shadow   = stage_len(bus.acc_len_reg);
    arm_rise = bus.arm & ~arm_q;
    boundary = bus.din_valid && (ch_cnt_q == '1);
    counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    int_end  = counting && boundary && (spec_cnt_q == acc_len_q - 32'd1);
    // A sync landing on channel 0 or on the last channel is on-grid.
    bad_sync = counting && bus.sync_in && (ch_cnt_q != '0) && !boundary;
  end

  // NOTE: every variable written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    spec_cnt_d  = spec_cnt_q;
    acc_len_d   = acc_len_q;
    dump_cnt_d  = dump_cnt_q;
    rst_timer_d = rst_timer_q;
    sync_out_d  = 1'b0;
    latch_len   = 1'b0;

    if (bus.sync_in)        ch_cnt_d = '0;
    else if (bus.din_valid) ch_cnt_d = ch_cnt_q + CHANNEL_ADDR'(1);
    else                    ch_cnt_d = ch_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (arm_rise) begin
          latch_len  = 1'b1;
          dump_cnt_d = '0;
          state_d    = ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        if (!bus.arm) begin
          state_d = ST_IDLE;
        end else if (bus.sync_in) begin
          sync_out_d  = 1'b1;
          rst_timer_d = RST_W'(RST_CYCLES);
          spec_cnt_d  = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        sync_out_d = bus.sync_in;
        if (rst_timer_q != '0) rst_timer_d = rst_timer_q - RST_W'(1);
        if (bad_sync) begin
          rst_timer_d = RST_W'(RST_CYCLES);
          spec_cnt_d  = '0;
        end else if (int_end) begin
          spec_cnt_d = '0;
          dump_cnt_d = dump_cnt_q + 32'd1;
          latch_len  = 1'b1;
          if (state_q == ST_DRAIN) state_d = ST_IDLE;
        end else if (boundary) begin
          spec_cnt_d = spec_cnt_q + 32'd1;
        end
        if (state_q == ST_RUN && !bus.arm) state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (latch_len) acc_len_d = shadow;

    // Counters are held in reset except while running past the start pulse.
    cnt_rst_d = !(((state_d == ST_RUN) || (state_d == ST_DRAIN)) && (rst_timer_d == '0));
  end

  always_comb begin
    set_to     = 1'b0;
    to_timer_d = to_timer_q;
    if (int_end) begin
      to_timer_d = TO_W'(TIMEOUT);
    end else if (bus.det_valid) begin
      to_timer_d = '0;
    end else if (to_timer_q != '0) begin
      to_timer_d = to_timer_q - TO_W'(1);
      set_to     = (to_timer_q == TO_W'(1));
    end

    set_warn = bus.det_warning && (state_q != ST_IDLE);
    set_sync = bad_sync;
    set_cfg  = latch_len && (bus.acc_len_reg == 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      arm_q       <= 1'b0;
      ch_cnt_q    <= '0;
      spec_cnt_q  <= '0;
      acc_len_q   <= 32'(ACC_LEN_DEFAULT);
      dump_cnt_q  <= '0;
      rst_timer_q <= '0;
      to_timer_q  <= '0;
      sync_out_q  <= 1'b0;
      cnt_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      arm_q       <= bus.arm;
      ch_cnt_q    <= ch_cnt_d;
      spec_cnt_q  <= spec_cnt_d;
      acc_len_q   <= acc_len_d;
      dump_cnt_q  <= dump_cnt_d;
      rst_timer_q <= rst_timer_d;
      to_timer_q  <= to_timer_d;
      sync_out_q  <= sync_out_d;
      cnt_rst_q   <= cnt_rst_d;
    end
  end

  rfi_sticky_flag u_warn (.clk(clk), .rst(rst), .set(set_warn), .clr(bus.warn_clr), .flag(bus.warn_sticky));
  rfi_sticky_flag u_sync (.clk(clk), .rst(rst), .set(set_sync), .clr(bus.warn_clr), .flag(bus.sync_err));
  rfi_sticky_flag u_cfg  (.clk(clk), .rst(rst), .set(set_cfg),  .clr(bus.warn_clr), .flag(bus.cfg_err));
  rfi_sticky_flag u_to   (.clk(clk), .rst(rst), .set(set_to),   .clr(bus.warn_clr), .flag(bus.dump_timeout));

  assign bus.acc_len  = acc_len_q;
  assign bus.cnt_rst  = cnt_rst_q;
  assign bus.sync_out = sync_out_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.state    = state_q;
  assign bus.dump_cnt = dump_cnt_q;

endmodule
